// File: rtl/pr_if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Holds the PC/instruction pair seen by decode. When a hold arrives while
// the 1-cycle-latency instruction memory already has a fetch in flight,
// that fetch is parked in the skid entry and replayed once the hold lifts.
// Also drives fetch back-pressure, a sticky skid-overflow flag and a
// saturating consecutive-hold counter for performance monitoring.
module pr_if_id_skid #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
  parameter int              HCNT_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [XLEN-1:0]   PC_IN,
  input  logic [XLEN-1:0]   INSTR_IN,
  input  logic              INSTR_VALID,
  input  logic              FLUSH,
  input  logic              HOLD,
  output logic [XLEN-1:0]   PC_OUT,
  output logic [XLEN-1:0]   INSTR_OUT,
  output logic              VALID_OUT,
  output logic              IF_STALL,
  output logic              SKID_OVF,
  output logic [HCNT_W-1:0] HOLD_CNT
);

  typedef enum logic {
    ST_PASS = 1'b0,   // skid entry empty
    ST_SKID = 1'b1    // skid entry holds a parked fetch
  } state_t;

  state_t            state_q, state_d;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              valid_q, valid_d;

  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;

  logic              ovf_q, ovf_d;
  logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // State register for the skid FSM.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_PASS;
    else        state_q <= state_d;
  end

  // Next-state and next-data logic: FLUSH beats HOLD beats normal capture.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    ovf_d        = ovf_q;

    if (FLUSH) begin
      // Branch/jump redirect: kill the decode slot and any parked fetch.
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = ST_PASS;
    end else begin
      unique case (state_q)
        ST_PASS: begin
          if (!HOLD) begin
            pc_d    = PC_IN;
            instr_d = INSTR_VALID ? INSTR_IN : NOP_INSTR;
            valid_d = INSTR_VALID;
          end else if (INSTR_VALID) begin
            // Fetch was already in flight when the hold hit: park it.
            skid_pc_d    = PC_IN;
            skid_instr_d = INSTR_IN;
            state_d      = ST_SKID;
          end
        end
        ST_SKID: begin
          if (!HOLD) begin
            pc_d    = skid_pc_q;
            instr_d = skid_instr_q;
            valid_d = 1'b1;
            state_d = ST_PASS;
          end
          // Fetch is stalled while the skid is full, so any valid input
          // here has nowhere to go and is lost.
          if (INSTR_VALID) ovf_d = 1'b1;
        end
        default: state_d = ST_PASS;
      endcase
    end
  end

  // Saturating count of consecutive hold cycles; any release or flush clears it.
  always_comb begin
    hold_cnt_d = '0;
    if (HOLD && !FLUSH) begin
      hold_cnt_d = (hold_cnt_q == {HCNT_W{1'b1}}) ? hold_cnt_q
                                                  : hold_cnt_q + HCNT_W'(1);
    end
  end

  // Decode-slot registers, skid storage, overflow flag and hold counter.
  // NOTE: the skid data flops are reset too, so a reset mid-hold leaves no
  // stale instruction behind even though occupancy alone would mask it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q         <= '0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      ovf_q        <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      ovf_q        <= ovf_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Fetch must stall during a hold and while a parked fetch awaits replay.
  // FLUSH is absent on purpose: the PC mux performs the redirect itself.
  assign IF_STALL  = HOLD | (state_q == ST_SKID);

  assign PC_OUT    = pc_q;
  assign INSTR_OUT = instr_q;
  assign VALID_OUT = valid_q;
  assign SKID_OVF  = ovf_q;
  assign HOLD_CNT  = hold_cnt_q;

endmodule

// File: tb/tb_pr_if_id_skid.sv
// Self-checking bench for pr_if_id_skid: directed scenarios followed by
// random traffic, compared against a queue-based reference model through a
// scoreboard drained by an independent monitor.
module tb_pr_if_id_skid;

  localparam int          XLEN    = 32;
  localparam int          HCNT_W  = 8;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam int          CNT_MAX = (1 << HCNT_W) - 1;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic [XLEN-1:0]   PC_IN = '0;
  logic [XLEN-1:0]   INSTR_IN = '0;
  logic              INSTR_VALID = 1'b0;
  logic              FLUSH = 1'b0;
  logic              HOLD = 1'b0;
  logic [XLEN-1:0]   PC_OUT;
  logic [XLEN-1:0]   INSTR_OUT;
  logic              VALID_OUT;
  logic              IF_STALL;
  logic              SKID_OVF;
  logic [HCNT_W-1:0] HOLD_CNT;

  pr_if_id_skid #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP),
    .HCNT_W    (HCNT_W)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC_IN       (PC_IN),
    .INSTR_IN    (INSTR_IN),
    .INSTR_VALID (INSTR_VALID),
    .FLUSH       (FLUSH),
    .HOLD        (HOLD),
    .PC_OUT      (PC_OUT),
    .INSTR_OUT   (INSTR_OUT),
    .VALID_OUT   (VALID_OUT),
    .IF_STALL    (IF_STALL),
    .SKID_OVF    (SKID_OVF),
    .HOLD_CNT    (HOLD_CNT)
  );

  always #5 CLK = ~CLK;

  // Expected observable state of the block between two edges.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  // Reference model: decode slot, a queue of parked fetches (capacity one),
  // sticky overflow flag and an integer hold counter.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_ovf;
  int          m_cnt;
  fetch_t      m_parked[$];

  task automatic model_reset();
    m_pc    = '0;
    m_instr = NOP;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_cnt   = 0;
    m_parked.delete();
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    fetch_t f;
    if (!RESET) begin
      model_reset();
      return;
    end
    if (FLUSH) begin
      m_pc = '0; m_instr = NOP; m_valid = 1'b0;
      m_parked.delete();
    end else if (HOLD) begin
      if (INSTR_VALID) begin
        if (m_parked.size() == 0) begin
          f.pc = PC_IN; f.instr = INSTR_IN;
          m_parked.push_back(f);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end else if (m_parked.size() != 0) begin
      f = m_parked.pop_front();
      m_pc = f.pc; m_instr = f.instr; m_valid = 1'b1;
      if (INSTR_VALID) m_ovf = 1'b1;
    end else begin
      m_pc    = PC_IN;
      m_instr = INSTR_VALID ? INSTR_IN : NOP;
      m_valid = INSTR_VALID;
    end
    if (HOLD && !FLUSH) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    else                m_cnt = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc    = m_pc;
    e.instr = m_instr;
    e.valid = m_valid;
    e.stall = HOLD | (m_parked.size() != 0);
    e.ovf   = m_ovf;
    e.cnt   = m_cnt[7:0];
    sb.push_back(e);
  endtask

  // One clock: model takes the edge, new inputs go on 1 ns later, and the
  // expectation for the coming interval is queued.
  task automatic cycle(input logic rst, input logic hold, input logic flush,
                       input logic iv, input logic [31:0] pc,
                       input logic [31:0] instr);
    @(posedge CLK);
    model_edge();
    #1;
    RESET = rst; HOLD = hold; FLUSH = flush;
    INSTR_VALID = iv; PC_IN = pc; INSTR_IN = instr;
    if (!rst) model_reset();
    push_exp();
  endtask

  // Like cycle(), but reset is asserted asynchronously between edges.
  task automatic cycle_reset_mid(input logic hold);
    @(posedge CLK);
    model_edge();
    #1;
    HOLD = hold; FLUSH = 1'b0; INSTR_VALID = 1'b0; PC_IN = '0; INSTR_IN = '0;
    #2;
    RESET = 1'b0;
    model_reset();
    push_exp();
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per interval, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pc_out",    PC_OUT,                 e.pc);
        check("instr_out", INSTR_OUT,              e.instr);
        check("valid_out", {31'b0, VALID_OUT},     {31'b0, e.valid});
        check("if_stall",  {31'b0, IF_STALL},      {31'b0, e.stall});
        check("skid_ovf",  {31'b0, SKID_OVF},      {31'b0, e.ovf});
        check("hold_cnt",  {24'b0, HOLD_CNT},      {24'b0, e.cnt});
      end
    end
  end

  // Stimulus.
  initial begin
    model_reset();

    // Reset, then release.
    cycle(1'b0, 0, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Stream three fetches.
    cycle(1'b1, 0, 0, 1, 32'h0, 32'hA0);
    cycle(1'b1, 0, 0, 1, 32'h4, 32'hA4);
    cycle(1'b1, 0, 0, 1, 32'h8, 32'hA8);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Hold with an in-flight fetch: 0x4 held, 0x8 parked, replayed later.
    cycle(1'b1, 0, 0, 1, 32'h4, 32'hA4);
    cycle(1'b1, 1, 0, 1, 32'h8, 32'hA8);
    cycle(1'b1, 1, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Flush with skid full: parked 0x8 must never appear.
    cycle(1'b1, 0, 0, 1, 32'h4, 32'hA4);
    cycle(1'b1, 1, 0, 1, 32'h8, 32'hA8);
    cycle(1'b1, 0, 1, 0, 32'h0, 32'h0);
    cycle(1'b1, 1, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Overflow: 0xC arrives while 0x8 is parked; flag survives a flush.
    cycle(1'b1, 0, 0, 1, 32'h4, 32'hA4);
    cycle(1'b1, 1, 0, 1, 32'h8, 32'hA8);
    cycle(1'b1, 1, 0, 1, 32'hC, 32'hAC);
    cycle(1'b1, 1, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 1, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 1, 32'h10, 32'hB0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Overflow on the release cycle itself, then simultaneous FLUSH+HOLD.
    cycle(1'b0, 0, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 1, 0, 1, 32'h20, 32'hC0);
    cycle(1'b1, 0, 0, 1, 32'h24, 32'hC4);
    cycle(1'b1, 1, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 1, 1, 1, 32'h28, 32'hC8);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Saturation of the hold counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, 1, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Async reset while a fetch is parked and HOLD is high.
    cycle(1'b1, 0, 0, 1, 32'h4, 32'hA4);
    cycle(1'b1, 1, 0, 1, 32'h8, 32'hA8);
    cycle_reset_mid(1'b1);
    cycle(1'b0, 1, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_hold, r_flush, r_iv;
      logic [31:0] r_pc, r_instr;
      r_rst   = ($urandom_range(0, 149) != 0);
      r_hold  = ($urandom_range(0, 9) < 4);
      r_flush = ($urandom_range(0, 14) == 0);
      r_iv    = ($urandom_range(0, 9) < 7);
      r_pc    = $urandom & 32'hFFFF_FFFC;
      r_instr = $urandom;
      cycle(r_rst, r_hold, r_flush, r_iv, r_pc, r_instr);
    end
    cycle(1'b1, 0, 0, 0, 32'h0, 32'h0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge CLK);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
